// File: rtl/fix_stream_sched.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : fix_stream_sched
// Description : Message-level round-robin scheduler sharing one fix_parser
//               between NREQ FIX byte-stream requesters. A grant covers a
//               whole message. The parser is resynchronised with a one-cycle
//               p_rst_o pulse before every message and after an abort. Bytes
//               reach the parser through one register stage. A requester that
//               stalls for TIMEOUT cycles mid-message is aborted.
// Ports       : clk, rst (async, active-high)
//               req_valid_i/req_data_i/req_last_i/req_ready_o : requesters
//               p_data_o/p_ctrl_o/p_rst_o                     : to parser
//               grant_o/grant_id_o/busy_o/abort_o             : status
// Options     : FIX_SCHED_SOH_CHECK_EN - abort when a message's last byte
//               is not SOH (8'h01).
// Revision    : 1.0 - initial release
// ============================================================================
module fix_stream_sched #(
    parameter int NREQ     = 4,
    parameter int IDLE_GAP = 2,
    parameter int TIMEOUT  = 255
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req_valid_i,
    input  logic [8*NREQ-1:0]       req_data_i,
    input  logic [NREQ-1:0]         req_last_i,
    output logic [NREQ-1:0]         req_ready_o,
    output logic [7:0]              p_data_o,
    output logic                    p_ctrl_o,
    output logic                    p_rst_o,
    output logic [NREQ-1:0]         grant_o,
    output logic [$clog2(NREQ)-1:0] grant_id_o,
    output logic                    busy_o,
    output logic                    abort_o
);

    localparam int ID_W = $clog2(NREQ);

    localparam logic [2:0] c_idle  = 3'd0;
    localparam logic [2:0] c_flush = 3'd1;
    localparam logic [2:0] c_xfer  = 3'd2;
    localparam logic [2:0] c_gap   = 3'd3;
    localparam logic [2:0] c_abort = 3'd4;

    localparam logic [15:0]     c_timeout_m1 = 16'(TIMEOUT - 1);
    // With IDLE_GAP = 0 the GAP state is never entered, so the wrapped value is unused.
    localparam logic [3:0]      c_gap_m1     = 4'(IDLE_GAP - 1);
    localparam logic [ID_W-1:0] c_last_id    = ID_W'(NREQ - 1);
    localparam bit              c_has_gap    = (IDLE_GAP != 0);

    logic [2:0]      r_state;
    logic [2:0]      w_state_nxt;
    logic [ID_W-1:0] r_ptr;
    logic [ID_W-1:0] r_gid;
    logic [15:0]     r_stall;
    logic [3:0]      r_gap;
    logic [7:0]      r_p_data;
    logic            r_p_ctrl;

    logic            w_sel_valid;
    logic            w_sel_last;
    logic [7:0]      w_sel_data;
    logic [NREQ-1:0] w_onehot;
    logic            w_pick_any;
    logic [ID_W-1:0] w_pick_id;
    int              w_scan;
    logic            w_acc;
    logic            w_bad_last;
    logic [ID_W-1:0] w_gid_inc;
    logic            w_busy;

    // Select the current owner's byte lane and build its one-hot code.
    always_comb begin
        w_sel_valid = 1'b0;
        w_sel_last  = 1'b0;
        w_sel_data  = 8'h00;
        w_onehot    = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (r_gid == ID_W'(k)) begin
                w_sel_valid = req_valid_i[k];
                w_sel_last  = req_last_i[k];
                w_sel_data  = req_data_i[8*k +: 8];
                w_onehot[k] = 1'b1;
            end
        end
    end

    // Round-robin pick: first valid requester at or after r_ptr, wrapping.
    always_comb begin
        w_pick_any = 1'b0;
        w_pick_id  = '0;
        w_scan     = 0;
        for (int i = 0; i < NREQ; i++) begin
            w_scan = int'(r_ptr) + i;
            if (w_scan >= NREQ) begin
                w_scan = w_scan - NREQ;
            end
            if (!w_pick_any && req_valid_i[w_scan[ID_W-1:0]]) begin
                w_pick_any = 1'b1;
                w_pick_id  = w_scan[ID_W-1:0];
            end
        end
    end

    assign w_acc     = (r_state == c_xfer) && w_sel_valid;
    assign w_gid_inc = (r_gid == c_last_id) ? '0 : r_gid + ID_W'(1);

`ifdef FIX_SCHED_SOH_CHECK_EN
    assign w_bad_last = w_sel_last && (w_sel_data != 8'h01);
`else
    assign w_bad_last = 1'b0;
`endif

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_idle: begin
                if (w_pick_any) begin
                    w_state_nxt = c_flush;
                end
            end
            c_flush: begin
                w_state_nxt = c_xfer;
            end
            c_xfer: begin
                if (w_acc) begin
                    if (w_sel_last) begin
                        if (w_bad_last) begin
                            w_state_nxt = c_abort;
                        end else if (c_has_gap) begin
                            w_state_nxt = c_gap;
                        end else begin
                            w_state_nxt = c_idle;
                        end
                    end
                end else if (r_stall == c_timeout_m1) begin
                    // This idle cycle brings the stall count to TIMEOUT.
                    w_state_nxt = c_abort;
                end
            end
            c_gap: begin
                if (r_gap == 4'd0) begin
                    w_state_nxt = c_idle;
                end
            end
            c_abort: begin
                w_state_nxt = c_idle;
            end
            default: begin
                w_state_nxt = c_idle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Owner, rotation pointer, counters and the parser-facing byte stage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr    <= '0;
            r_gid    <= '0;
            r_stall  <= 16'd0;
            r_gap    <= 4'd0;
            r_p_data <= 8'h00;
            r_p_ctrl <= 1'b0;
        end else begin
            r_p_ctrl <= w_acc;
            if (w_acc) begin
                r_p_data <= w_sel_data;
            end
            case (r_state)
                c_idle: begin
                    if (w_pick_any) begin
                        r_gid <= w_pick_id;
                    end
                end
                c_flush: begin
                    r_stall <= 16'd0;
                end
                c_xfer: begin
                    if (w_acc) begin
                        r_stall <= 16'd0;
                        r_gap   <= c_gap_m1;
                        // A rejected last byte rotates the pointer in ABORT instead.
                        if (w_sel_last && !w_bad_last) begin
                            r_ptr <= w_gid_inc;
                        end
                    end else begin
                        r_stall <= r_stall + 16'd1;
                    end
                end
                c_gap: begin
                    r_gap <= r_gap - 4'd1;
                end
                c_abort: begin
                    r_ptr <= w_gid_inc;
                end
                default: begin
                end
            endcase
        end
    end

    assign w_busy      = (r_state != c_idle);
    assign busy_o      = w_busy;
    // Ready depends only on state and owner so a requester never sees a
    // combinational path from its own valid.
    assign req_ready_o = (r_state == c_xfer) ? w_onehot : '0;
    assign grant_o     = w_busy ? w_onehot : '0;
    assign grant_id_o  = w_busy ? r_gid : '0;
    assign p_rst_o     = (r_state == c_flush) || (r_state == c_abort);
    assign abort_o     = (r_state == c_abort);
    assign p_data_o    = r_p_data;
    assign p_ctrl_o    = r_p_ctrl;

endmodule
`default_nettype wire

// File: tb/tb_fix_stream_sched.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_fix_stream_sched
// Description : Directed self-checking bench for fix_stream_sched. Instance a
//               uses IDLE_GAP=2, instance b uses IDLE_GAP=0; both TIMEOUT=8.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fix_stream_sched;

    localparam int N = 4;
`ifdef FIX_SCHED_SOH_CHECK_EN
    localparam bit SOH_EN = 1'b1;
`else
    localparam bit SOH_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic [N-1:0]   valid [2];
    logic [8*N-1:0] data  [2];
    logic [N-1:0]   last  [2];

    logic [N-1:0] a_ready, b_ready, a_grant, b_grant;
    logic [7:0]   a_data, b_data;
    logic         a_ctrl, b_ctrl, a_prst, b_prst, a_busy, b_busy, a_abort, b_abort;
    logic [1:0]   a_gid, b_gid;

    fix_stream_sched #(.NREQ(N), .IDLE_GAP(2), .TIMEOUT(8)) dut_a (
        .clk(clk), .rst(rst),
        .req_valid_i(valid[0]), .req_data_i(data[0]), .req_last_i(last[0]),
        .req_ready_o(a_ready), .p_data_o(a_data), .p_ctrl_o(a_ctrl), .p_rst_o(a_prst),
        .grant_o(a_grant), .grant_id_o(a_gid), .busy_o(a_busy), .abort_o(a_abort)
    );

    fix_stream_sched #(.NREQ(N), .IDLE_GAP(0), .TIMEOUT(8)) dut_b (
        .clk(clk), .rst(rst),
        .req_valid_i(valid[1]), .req_data_i(data[1]), .req_last_i(last[1]),
        .req_ready_o(b_ready), .p_data_o(b_data), .p_ctrl_o(b_ctrl), .p_rst_o(b_prst),
        .grant_o(b_grant), .grant_id_o(b_gid), .busy_o(b_busy), .abort_o(b_abort)
    );

    // Requester message store: {last, byte} per entry.
    logic [8:0] msg [2][N][16];
    int         len [2][N];
    int         pos [2][N];

    // Per-cycle log; index = cycles since reset release.
    logic [7:0]   lg_data  [2][64];
    logic         lg_ctrl  [2][64];
    logic         lg_rst   [2][64];
    logic         lg_abort [2][64];
    logic         lg_busy  [2][64];
    logic [N-1:0] lg_grant [2][64];
    logic [N-1:0] lg_ready [2][64];
    logic [1:0]   lg_gid   [2][64];
    int cyc;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic clear_msgs();
        for (int d = 0; d < 2; d++) begin
            for (int k = 0; k < N; k++) begin
                len[d][k] = 0;
                pos[d][k] = 0;
            end
        end
    endtask

    task automatic add_byte(input int d, input int k, input logic [7:0] b, input logic l);
        msg[d][k][len[d][k]] = {l, b};
        len[d][k] = len[d][k] + 1;
    endtask

    task automatic add_str(input int d, input int k, input string s);
        for (int i = 0; i < s.len(); i++) begin
            add_byte(d, k, s[i], 1'b0);
        end
    endtask

    task automatic drive();
        for (int d = 0; d < 2; d++) begin
            for (int k = 0; k < N; k++) begin
                if (pos[d][k] < len[d][k]) begin
                    valid[d][k]       = 1'b1;
                    data[d][8*k +: 8] = msg[d][k][pos[d][k]][7:0];
                    last[d][k]        = msg[d][k][pos[d][k]][8];
                end else begin
                    valid[d][k]       = 1'b0;
                    data[d][8*k +: 8] = 8'h00;
                    last[d][k]        = 1'b0;
                end
            end
        end
    endtask

    task automatic snap();
        if (cyc < 64) begin
            lg_data[0][cyc] = a_data;   lg_data[1][cyc] = b_data;
            lg_ctrl[0][cyc] = a_ctrl;   lg_ctrl[1][cyc] = b_ctrl;
            lg_rst[0][cyc] = a_prst;    lg_rst[1][cyc] = b_prst;
            lg_abort[0][cyc] = a_abort; lg_abort[1][cyc] = b_abort;
            lg_busy[0][cyc] = a_busy;   lg_busy[1][cyc] = b_busy;
            lg_grant[0][cyc] = a_grant; lg_grant[1][cyc] = b_grant;
            lg_ready[0][cyc] = a_ready; lg_ready[1][cyc] = b_ready;
            lg_gid[0][cyc] = a_gid;     lg_gid[1][cyc] = b_gid;
        end
    endtask

    task automatic step();
        logic [N-1:0] acc0, acc1;
        drive();
        acc0 = valid[0] & a_ready;
        acc1 = valid[1] & b_ready;
        @(posedge clk);
        #1;
        cyc = cyc + 1;
        for (int k = 0; k < N; k++) begin
            if (acc0[k]) pos[0][k] = pos[0][k] + 1;
            if (acc1[k]) pos[1][k] = pos[1][k] + 1;
        end
        drive();
        snap();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_msgs();
        drive();
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc = 0;
        snap();
    endtask

    task automatic test_reset();
        #1 rst = 1'b1;
        clear_msgs();
        drive();
        #1;
        n_checks++;
        if ({a_ready, a_data, a_ctrl, a_prst, a_grant, a_gid, a_busy, a_abort} !== 22'd0) begin
            n_fail++;
            $display("FAIL reset_a: got %h expected 0", {a_ready, a_data, a_ctrl, a_prst, a_grant, a_gid, a_busy, a_abort});
        end
        n_checks++;
        if ({b_ready, b_data, b_ctrl, b_prst, b_grant, b_gid, b_busy, b_abort} !== 22'd0) begin
            n_fail++;
            $display("FAIL reset_b: got %h expected 0", {b_ready, b_data, b_ctrl, b_prst, b_grant, b_gid, b_busy, b_abort});
        end
    endtask

    task automatic test_single_msg();
        do_reset();
        add_str(0, 0, "8=FIX.4.2");
        add_byte(0, 0, 8'h01, 1'b0);
        add_str(0, 0, "9=5");
        add_byte(0, 0, 8'h01, 1'b1);
        run(20);
        n_checks++;
        if ({lg_rst[0][1], lg_rst[0][2], lg_ctrl[0][2]} !== 3'b100) begin
            n_fail++;
            $display("FAIL single_flush: got rst1/rst2/ctrl2=%b expected 100", {lg_rst[0][1], lg_rst[0][2], lg_ctrl[0][2]});
        end
        for (int i = 0; i < 14; i++) begin
            n_checks++;
            if ({lg_ctrl[0][3+i], lg_data[0][3+i]} !== {1'b1, msg[0][0][i][7:0]}) begin
                n_fail++;
                $display("FAIL single_byte%0d: got ctrl/data %h expected %h", i, {lg_ctrl[0][3+i], lg_data[0][3+i]}, {1'b1, msg[0][0][i][7:0]});
            end
        end
        n_checks++;
        if ({lg_ctrl[0][17], lg_data[0][17], lg_busy[0][17], lg_grant[0][17]} !== {1'b0, 8'h01, 1'b1, 4'b0001}) begin
            n_fail++;
            $display("FAIL single_gap: got %h expected %h", {lg_ctrl[0][17], lg_data[0][17], lg_busy[0][17], lg_grant[0][17]}, {1'b0, 8'h01, 1'b1, 4'b0001});
        end
        n_checks++;
        if ({lg_busy[0][18], lg_grant[0][18], lg_ctrl[0][18]} !== 6'd0) begin
            n_fail++;
            $display("FAIL single_idle: got busy/grant/ctrl %h expected 0", {lg_busy[0][18], lg_grant[0][18], lg_ctrl[0][18]});
        end
    endtask

    task automatic test_round_robin();
        logic [7:0] exp_b [12];
        logic [1:0] exp_g [4];
        int nctrl;
        exp_b = '{8'h41, 8'h42, 8'h01, 8'h61, 8'h62, 8'h01, 8'h78, 8'h79, 8'h01, 8'h44, 8'h45, 8'h01};
        exp_g = '{2'd0, 2'd1, 2'd3, 2'd0};
        do_reset();
        add_str(0, 0, "AB"); add_byte(0, 0, 8'h01, 1'b1);
        add_str(0, 0, "DE"); add_byte(0, 0, 8'h01, 1'b1);
        add_str(0, 1, "ab"); add_byte(0, 1, 8'h01, 1'b1);
        add_str(0, 3, "xy"); add_byte(0, 3, 8'h01, 1'b1);
        run(30);
        for (int m = 0; m < 4; m++) begin
            n_checks++;
            if ({lg_rst[0][1+7*m], lg_gid[0][1+7*m]} !== {1'b1, exp_g[m]}) begin
                n_fail++;
                $display("FAIL rr_grant%0d: got rst/gid %h expected %h", m, {lg_rst[0][1+7*m], lg_gid[0][1+7*m]}, {1'b1, exp_g[m]});
            end
            for (int j = 0; j < 3; j++) begin
                n_checks++;
                if ({lg_ctrl[0][3+7*m+j], lg_data[0][3+7*m+j]} !== {1'b1, exp_b[3*m+j]}) begin
                    n_fail++;
                    $display("FAIL rr_byte%0d: got %h expected %h", 3*m+j, {lg_ctrl[0][3+7*m+j], lg_data[0][3+7*m+j]}, {1'b1, exp_b[3*m+j]});
                end
            end
        end
        nctrl = 0;
        for (int c = 1; c <= 30; c++) nctrl += int'(lg_ctrl[0][c]);
        n_checks++;
        if (nctrl !== 12) begin
            n_fail++;
            $display("FAIL rr_ctrl_count: got %0d expected 12", nctrl);
        end
        n_checks++;
        if (lg_grant[0][8] !== 4'b0010) begin
            n_fail++;
            $display("FAIL rr_onehot: got %b expected 0010", lg_grant[0][8]);
        end
    endtask

    task automatic test_timeout();
        int nctrl;
        do_reset();
        add_str(0, 2, "cd");
        add_str(0, 3, "Z"); add_byte(0, 3, 8'h01, 1'b1);
        run(18);
        n_checks++;
        if ({lg_gid[0][1], lg_ready[0][1], lg_ready[0][2]} !== {2'd2, 4'b0000, 4'b0100}) begin
            n_fail++;
            $display("FAIL to_grant: got gid/ready %h expected %h", {lg_gid[0][1], lg_ready[0][1], lg_ready[0][2]}, {2'd2, 4'b0000, 4'b0100});
        end
        n_checks++;
        if ({lg_data[0][3], lg_data[0][4]} !== {8'h63, 8'h64}) begin
            n_fail++;
            $display("FAIL to_bytes: got %h expected 6364", {lg_data[0][3], lg_data[0][4]});
        end
        nctrl = 0;
        for (int c = 5; c <= 12; c++) nctrl += int'(lg_ctrl[0][c]);
        n_checks++;
        if (nctrl !== 0) begin
            n_fail++;
            $display("FAIL to_stall_ctrl: got %0d expected 0", nctrl);
        end
        n_checks++;
        if ({lg_abort[0][11], lg_abort[0][12], lg_rst[0][12], lg_abort[0][13], lg_busy[0][13]} !== 5'b01100) begin
            n_fail++;
            $display("FAIL to_abort: got %b expected 01100", {lg_abort[0][11], lg_abort[0][12], lg_rst[0][12], lg_abort[0][13], lg_busy[0][13]});
        end
        n_checks++;
        if ({lg_gid[0][14], lg_ctrl[0][16], lg_data[0][16]} !== {2'd3, 1'b1, 8'h5a}) begin
            n_fail++;
            $display("FAIL to_next: got %h expected %h", {lg_gid[0][14], lg_ctrl[0][16], lg_data[0][16]}, {2'd3, 1'b1, 8'h5a});
        end
    endtask

    task automatic test_reset_mid_msg();
        do_reset();
        add_str(0, 0, "AB"); add_byte(0, 0, 8'h01, 1'b1);
        add_str(0, 1, "1234567"); add_byte(0, 1, 8'h01, 1'b1);
        run(14);
        n_checks++;
        if ({lg_gid[0][8], lg_ctrl[0][14], lg_data[0][14]} !== {2'd1, 1'b1, 8'h35}) begin
            n_fail++;
            $display("FAIL mid_pre: got %h expected %h", {lg_gid[0][8], lg_ctrl[0][14], lg_data[0][14]}, {2'd1, 1'b1, 8'h35});
        end
        rst = 1'b1;
        #1;
        n_checks++;
        if ({a_ready, a_data, a_ctrl, a_prst, a_grant, a_gid, a_busy, a_abort} !== 22'd0) begin
            n_fail++;
            $display("FAIL mid_async: got %h expected 0", {a_ready, a_data, a_ctrl, a_prst, a_grant, a_gid, a_busy, a_abort});
        end
        clear_msgs();
        add_str(0, 0, "Q"); add_byte(0, 0, 8'h01, 1'b1);
        add_str(0, 1, "R"); add_byte(0, 1, 8'h01, 1'b1);
        drive();
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc = 0;
        snap();
        run(4);
        n_checks++;
        if ({lg_busy[0][0], lg_grant[0][1], lg_ctrl[0][3], lg_data[0][3]} !== {1'b0, 4'b0001, 1'b1, 8'h51}) begin
            n_fail++;
            $display("FAIL mid_after: got %h expected %h", {lg_busy[0][0], lg_grant[0][1], lg_ctrl[0][3], lg_data[0][3]}, {1'b0, 4'b0001, 1'b1, 8'h51});
        end
    endtask

    task automatic test_soh_check();
        int nab;
        do_reset();
        add_str(0, 1, "ab");
        add_byte(0, 1, 8'h7c, 1'b1);
        run(10);
        n_checks++;
        if ({lg_gid[0][1], lg_ctrl[0][5], lg_data[0][5]} !== {2'd1, 1'b1, 8'h7c}) begin
            n_fail++;
            $display("FAIL soh_fwd: got %h expected %h", {lg_gid[0][1], lg_ctrl[0][5], lg_data[0][5]}, {2'd1, 1'b1, 8'h7c});
        end
        n_checks++;
        if ({lg_abort[0][5], lg_rst[0][5], lg_busy[0][6]} !== {SOH_EN, SOH_EN, !SOH_EN}) begin
            n_fail++;
            $display("FAIL soh_end: got %b expected %b", {lg_abort[0][5], lg_rst[0][5], lg_busy[0][6]}, {SOH_EN, SOH_EN, !SOH_EN});
        end
        nab = 0;
        for (int c = 1; c <= 10; c++) nab += int'(lg_abort[0][c]);
        n_checks++;
        if (nab !== (SOH_EN ? 1 : 0)) begin
            n_fail++;
            $display("FAIL soh_abort_count: got %0d expected %0d", nab, SOH_EN ? 1 : 0);
        end
    endtask

    task automatic test_back_to_back();
        logic [9:0] exp_ctrl;
        logic [7:0] exp_d [6];
        int cyc_d [6];
        exp_ctrl = 10'b1100110011;   // cycles 12 down to 3
        exp_d = '{8'h50, 8'h01, 8'h72, 8'h01, 8'h51, 8'h01};
        cyc_d = '{3, 4, 7, 8, 11, 12};
        do_reset();
        add_str(1, 0, "P"); add_byte(1, 0, 8'h01, 1'b1);
        add_str(1, 0, "Q"); add_byte(1, 0, 8'h01, 1'b1);
        add_str(1, 1, "r"); add_byte(1, 1, 8'h01, 1'b1);
        run(14);
        n_checks++;
        if ({lg_gid[1][1], lg_gid[1][5], lg_gid[1][9], lg_rst[1][5], lg_busy[1][4]} !== {2'd0, 2'd1, 2'd0, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL b2b_grants: got %b expected %b", {lg_gid[1][1], lg_gid[1][5], lg_gid[1][9], lg_rst[1][5], lg_busy[1][4]}, {2'd0, 2'd1, 2'd0, 1'b1, 1'b0});
        end
        for (int c = 3; c <= 12; c++) begin
            n_checks++;
            if (lg_ctrl[1][c] !== exp_ctrl[c-3]) begin
                n_fail++;
                $display("FAIL b2b_ctrl_c%0d: got %b expected %b", c, lg_ctrl[1][c], exp_ctrl[c-3]);
            end
        end
        for (int i = 0; i < 6; i++) begin
            n_checks++;
            if (lg_data[1][cyc_d[i]] !== exp_d[i]) begin
                n_fail++;
                $display("FAIL b2b_data%0d: got %h expected %h", i, lg_data[1][cyc_d[i]], exp_d[i]);
            end
        end
    endtask

    initial begin
        cyc = 0;
        test_reset();
        test_single_msg();
        test_round_robin();
        test_timeout();
        test_reset_mid_msg();
        test_soh_check();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/fix_stream_sched.md
# fix_stream_sched

Message-level round-robin scheduler that shares one `fix_parser` instance between `NREQ` FIX byte-stream requesters (one per session). It grants the parser to one requester for a whole message and resynchronises the parser with a reset pulse before each message. It forwards bytes through a registered stage onto the parser's `data_i`/`ctrl`, and aborts any requester that stalls mid-message. It sits between the per-session ingress FIFOs and the parser.

## Interface
- `NREQ`, 4: number of requesters, 2..8.
- `IDLE_GAP`, 2: idle cycles inserted between messages, 0..15.
- `TIMEOUT`, 255: consecutive no-data cycles in XFER before abort, 1..65535.
- `clk` in 1: sole clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `req_valid_i` in NREQ: byte valid per requester.
- `req_data_i` in 8*NREQ: byte per requester; requester k uses bits [8k+7:8k].
- `req_last_i` in NREQ: marks the final byte of a message; qualified by valid.
- `req_ready_o` out NREQ: byte accepted when valid&ready.
- `p_data_o` out 8: to parser `data_i`.
- `p_ctrl_o` out 1: to parser `ctrl`; high exactly on cycles carrying a forwarded byte.
- `p_rst_o` out 1: to parser `rst`; one-cycle resync pulse.
- `grant_o` out NREQ: one-hot current owner; zero when idle.
- `grant_id_o` out $clog2(NREQ): binary owner index.
- `busy_o` out 1: state != IDLE.
- `abort_o` out 1: one-cycle pulse on timeout or check abort.

## Operation
- States: IDLE, FLUSH, XFER, GAP, ABORT.
- IDLE: if any `req_valid_i` is high, pick the first valid index at or after `ptr` (wrapping). Register the grant and go to FLUSH. No byte is accepted in IDLE.
- FLUSH: `p_rst_o`=1 for exactly one cycle, then XFER.
- XFER: `req_ready_o[g]`=1 and all other ready bits are 0.
  - Accepted byte: `p_data_o`<=byte and `p_ctrl_o`<=1 on the next edge; otherwise `p_ctrl_o`<=0 and `p_data_o` holds.
  - Accepted byte with `req_last_i`: `ptr`<=g+1 mod NREQ, go to GAP (or IDLE if `IDLE_GAP`=0).
- Stall counter: 16 bits. Cleared on FLUSH and on every accepted byte; increments on XFER cycles without acceptance.
  - Reaching `TIMEOUT` -> ABORT.
  - Requester valid dropping mid-message is legal until timeout.
- GAP: counts `IDLE_GAP` cycles with `p_ctrl_o`=0, then IDLE.
- ABORT: one cycle with `p_rst_o`=1 and `abort_o`=1, `ptr`<=g+1 mod NREQ, then IDLE. Bytes already forwarded are not recalled.
- Requests arriving while busy wait; ready stays low until granted.
- Rotation is fair: a requester with continuous messages cannot take two consecutive grants while another requester is valid in IDLE.

## Timing
- Reset values:
  - State IDLE, `ptr`=0.
  - `p_data_o`=8'h00, `p_ctrl_o`=0, `p_rst_o`=0.
  - `grant_o`=0, `grant_id_o`=0, `busy_o`=0, `abort_o`=0.
  - `req_ready_o`=0, stall counter=0.
- `req_ready_o` is combinational from state and grant only, never from valid.
- Request-to-first-accept: valid seen in IDLE at edge n; FLUSH during n..n+1; first accept at edge n+2.
- Accept-to-parser latency: 1 cycle, registered.
- Throughput in XFER: 1 byte/cycle.
- Min message-to-message spacing: last accept -> `IDLE_GAP` GAP cycles -> 1 IDLE cycle -> 1 FLUSH cycle -> next accept.
- `grant_o`/`grant_id_o` are valid from FLUSH through GAP/ABORT and are cleared on entering IDLE.
- `rst` asserted mid-message: all outputs return to reset values asynchronously; the partial message is dropped and the parser sees no `p_rst_o` pulse (parser shares `rst`).

## Configuration
- `FIX_SCHED_SOH_CHECK_EN` defined:
  - The byte accepted with `req_last_i` must be 8'h01 (SOH).
  - If it is not, the byte is still forwarded, then ABORT replaces GAP.
  - A `last` byte of 8'h01 behaves normally.
- `FIX_SCHED_SOH_CHECK_EN` undefined: `last` byte value is not inspected and `abort_o` fires only on timeout.

## Test plan
- Single requester 0 sends "8=FIX.4.2" SOH "9=5" SOH, last on the final 8'h01 -> `p_rst_o` pulse 1 cycle before the first byte. `p_ctrl_o` is high for 14 consecutive cycles with bytes in order. GAP lasts 2 cycles and `grant_o` returns to 0.
- Requesters 0, 1 and 3 all valid from reset, each with a 3-byte message -> grants in order 0, 1, 3, then 0 again. No byte from a non-granted requester appears on `p_data_o`.
- Requester 2 granted, sends 2 bytes then drops valid, `TIMEOUT`=8 -> after 8 stall cycles `abort_o` and `p_rst_o` pulse together. The next grant goes to 3 (or 0 if 3 is idle).
- Reset asserted during the 5th byte of a message -> all outputs are 0 within the same cycle. After release, IDLE with `ptr`=0 and requester 0 is granted first.
- With `FIX_SCHED_SOH_CHECK_EN`, requester 1 ends a message with 8'h7c ('|') -> the byte is forwarded, then ABORT. Without the macro, the same stimulus yields a normal GAP and no `abort_o`.
- `IDLE_GAP`=0, requester 0 back-to-back messages while requester 1 is valid -> requester 1 is granted between them. Spacing is exactly 2 cycles of `p_ctrl_o`=0.
